// File: rtl/rggen_counter_pkg.sv
// rggen_counter_pkg: counter overflow-mode enum and an all-ones helper sized by counter width
package rggen_counter_pkg;
  typedef enum logic {COUNTER_WRAP, COUNTER_SATURATE} rggen_counter_mode_e;
  function automatic logic [31:0] all_ones(int width);
    return (width >= 32) ? 32'hffff_ffff : (32'd1 << width) - 32'd1;
  endfunction
endpackage

// File: rtl/rggen_counter_cell.sv
// rggen_counter_cell: one up/down counter channel with sticky overflow/underflow flags and clear > sw write > up/down priority
module rggen_counter_cell
  import rggen_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter rggen_counter_mode_e MODE = COUNTER_WRAP
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_sw_write,
  input  logic [WIDTH-1:0] i_sw_mask,
  input  logic [WIDTH-1:0] i_sw_data,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_flag_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_overflow,
  output logic             o_underflow
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(all_ones(WIDTH));
  localparam logic SAT = (MODE == COUNTER_SATURATE);
  logic sw_hit, inc, dec, ovf, unf;
  logic [WIDTH-1:0] count_next;
  always_comb begin
    sw_hit = i_sw_write & |i_sw_mask;
    inc = ~i_clear & ~sw_hit & i_up & ~i_down;
    dec = ~i_clear & ~sw_hit & i_down & ~i_up;
    ovf = inc & (o_count == MAX);
    unf = dec & (o_count == '0);
    count_next = i_clear ? INITIAL_VALUE :
                 sw_hit ? (o_count & ~i_sw_mask) | (i_sw_data & i_sw_mask) :
                 ((ovf | unf) & SAT) ? o_count :
                 inc ? o_count + WIDTH'(1) :
                 dec ? o_count - WIDTH'(1) : o_count;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= INITIAL_VALUE;
      o_overflow <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_count <= count_next;
      o_overflow <= ~i_clear & (ovf | (o_overflow & ~i_flag_clear));
      o_underflow <= ~i_clear & (unf | (o_underflow & ~i_flag_clear));
    end
  end
endmodule

// File: rtl/rggen_bit_field_counter_array.sv
// rggen_bit_field_counter_array: CHANNELS packed counters with sw write/read bus, sticky flags and coherent snapshot shadow
module rggen_bit_field_counter_array
  import rggen_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter rggen_counter_mode_e MODE = COUNTER_WRAP,
  parameter int SNAPSHOT = 1
)(
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_sw_valid,
  input  logic                               i_sw_write,
  input  logic [CHANNELS*WIDTH-1:0]          i_sw_mask,
  input  logic [CHANNELS*WIDTH-1:0]          i_sw_data,
  output logic [CHANNELS*WIDTH-1:0]          o_sw_read_data,
  input  logic [CHANNELS-1:0]                i_clear,
  input  logic [CHANNELS-1:0]                i_up,
  input  logic [CHANNELS-1:0]                i_down,
  input  logic [CHANNELS-1:0]                i_flag_clear,
  input  logic                               i_snapshot,
  output logic [CHANNELS-1:0][WIDTH-1:0]     o_count,
  output logic [CHANNELS-1:0]                o_overflow,
  output logic [CHANNELS-1:0]                o_underflow
);
  logic [CHANNELS*WIDTH-1:0] shadow;
  logic sw_wr;
  assign sw_wr = i_sw_valid & i_sw_write;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    rggen_counter_cell #(
      .WIDTH(WIDTH),
      .INITIAL_VALUE(INITIAL_VALUE),
      .MODE(MODE)
    ) u_cell (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_clear(i_clear[i]),
      .i_sw_write(sw_wr),
      .i_sw_mask(i_sw_mask[i*WIDTH+:WIDTH]),
      .i_sw_data(i_sw_data[i*WIDTH+:WIDTH]),
      .i_up(i_up[i]),
      .i_down(i_down[i]),
      .i_flag_clear(i_flag_clear[i]),
      .o_count(o_count[i]),
      .o_overflow(o_overflow[i]),
      .o_underflow(o_underflow[i])
    );
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) shadow <= {CHANNELS{INITIAL_VALUE}};
    else if (i_snapshot) shadow <= o_count;
  end
  always_comb begin
    o_sw_read_data = (i_sw_valid & ~i_sw_write) ? (((SNAPSHOT != 0) ? shadow : o_count) & i_sw_mask) : '0;
  end
endmodule

// File: tb/tb_rggen_bit_field_counter_array.sv
// tb_rggen_bit_field_counter_array: self-checking bench for wrap and saturate counter arrays against a behavioural model
module tb_rggen_bit_field_counter_array;
  import rggen_counter_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic sw_valid = 1'b0, sw_write = 1'b0, snap = 1'b0;
  logic [15:0] sw_mask = '0, sw_data = '0;
  logic [3:0] clear = '0, up = '0, down = '0, fc = '0;
  logic [15:0] rd_w, rd_s;
  logic [3:0][3:0] cnt_w, cnt_s;
  logic [3:0] ov_w, un_w, ov_s, un_s;
  int checks = 0, errors = 0;
  int m_cnt[2][4], m_sh[2][4];
  bit m_ov[2][4], m_un[2][4];
  typedef struct {
    logic [3:0] clear, up, down;
    logic sw_write;
    logic [15:0] mask, data;
    int exp_c2, exp_c3;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  rggen_bit_field_counter_array #(.WIDTH(4), .CHANNELS(4), .INITIAL_VALUE(4'h0), .MODE(COUNTER_WRAP), .SNAPSHOT(1)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_sw_valid(sw_valid), .i_sw_write(sw_write), .i_sw_mask(sw_mask), .i_sw_data(sw_data),
    .o_sw_read_data(rd_w), .i_clear(clear), .i_up(up), .i_down(down), .i_flag_clear(fc), .i_snapshot(snap),
    .o_count(cnt_w), .o_overflow(ov_w), .o_underflow(un_w));
  rggen_bit_field_counter_array #(.WIDTH(4), .CHANNELS(4), .INITIAL_VALUE(4'h0), .MODE(COUNTER_SATURATE), .SNAPSHOT(1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_sw_valid(sw_valid), .i_sw_write(sw_write), .i_sw_mask(sw_mask), .i_sw_data(sw_data),
    .o_sw_read_data(rd_s), .i_clear(clear), .i_up(up), .i_down(down), .i_flag_clear(fc), .i_snapshot(snap),
    .o_count(cnt_s), .o_overflow(ov_s), .o_underflow(un_s));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pack(input int v[4]);
    logic [15:0] r = '0;
    for (int c = 0; c < 4; c++) r[c*4+:4] = v[c][3:0];
    return r;
  endfunction

  function automatic logic [3:0] pack_b(input bit v[4]);
    logic [3:0] r = '0;
    for (int c = 0; c < 4; c++) r[c] = v[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 4; c++) begin
        m_cnt[m][c] = 0; m_sh[m][c] = 0; m_ov[m][c] = 0; m_un[m][c] = 0;
      end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (snap) m_sh[m] = m_cnt[m];
      for (int c = 0; c < 4; c++) begin
        int mk, d;
        mk = int'(sw_mask[c*4+:4]);
        d = int'(sw_data[c*4+:4]);
        if (fc[c]) begin m_ov[m][c] = 0; m_un[m][c] = 0; end
        if (clear[c]) begin
          m_cnt[m][c] = 0; m_ov[m][c] = 0; m_un[m][c] = 0;
        end else if (sw_valid && sw_write && mk != 0)
          m_cnt[m][c] = (m_cnt[m][c] & ~mk & 15) | (d & mk);
        else if (up[c] && !down[c]) begin
          if (m_cnt[m][c] == 15) begin m_ov[m][c] = 1; m_cnt[m][c] = (m == 1) ? 15 : 0; end
          else m_cnt[m][c]++;
        end else if (down[c] && !up[c]) begin
          if (m_cnt[m][c] == 0) begin m_un[m][c] = 1; m_cnt[m][c] = (m == 1) ? 0 : 15; end
          else m_cnt[m][c]--;
        end
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [15:0] er;
    for (int m = 0; m < 2; m++) begin
      er = (sw_valid && !sw_write) ? (pack(m_sh[m]) & sw_mask) : 16'h0;
      chk({tag, m ? "_s_count" : "_w_count"}, m ? cnt_s : cnt_w, pack(m_cnt[m]));
      chk({tag, m ? "_s_ovf" : "_w_ovf"}, {12'h0, m ? ov_s : ov_w}, {12'h0, pack_b(m_ov[m])});
      chk({tag, m ? "_s_unf" : "_w_unf"}, {12'h0, m ? un_s : un_w}, {12'h0, pack_b(m_un[m])});
      chk({tag, m ? "_s_rd" : "_w_rd"}, m ? rd_s : rd_w, er);
    end
  endtask

  task automatic idle();
    sw_valid = 0; sw_write = 0; sw_mask = '0; sw_data = '0;
    clear = '0; up = '0; down = '0; fc = '0; snap = 0;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    model_check(tag);
  endtask

  initial begin
    vecs[0] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 16'h0F00, 16'h0A00, 0, 0};
    vecs[1] = '{4'b0000, 4'b0100, 4'b0000, 1'b1, 16'h0F00, 16'h0A00, 10, 0};
    vecs[2] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 16'hF000, 16'h7000, 10, 7};
    for (int i = 3; i < 8; i++) vecs[i] = '{4'b0000, 4'b1000, 4'b1000, 1'b0, 16'h0, 16'h0, 10, 7};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    model_check("reset");
    rst = 0;
    #1;

    for (int k = 1; k <= 16; k++) begin
      up = 4'b0001;
      tick("wrap");
      chk("wrap_step", {12'h0, cnt_w[0]}, 16'(k % 16));
    end
    idle();
    chk("wrap_ovf0", {15'h0, ov_w[0]}, 16'h1);
    chk("sat_top", {12'h0, cnt_s[0]}, 16'hF);
    chk("others_zero", {4'h0, cnt_w[3], cnt_w[2], cnt_w[1]}, 16'h0);

    down = 4'b0010;
    tick("sat_dn");
    chk("sat_unf1", {12'h0, cnt_s[1], 3'b0, un_s[1]}, 16'h1);
    fc = 4'b0010;
    tick("sat_setwins");
    chk("sat_setwins_flag", {15'h0, un_s[1]}, 16'h1);
    idle();
    fc = 4'b0010;
    tick("sat_fc");
    chk("sat_fc_flag", {15'h0, un_s[1]}, 16'h0);
    idle();

    for (int i = 0; i < 8; i++) begin
      clear = vecs[i].clear; up = vecs[i].up; down = vecs[i].down;
      sw_valid = vecs[i].sw_write; sw_write = vecs[i].sw_write;
      sw_mask = vecs[i].mask; sw_data = vecs[i].data;
      tick("vec");
      chk($sformatf("vec%0d_c2", i), {12'h0, cnt_w[2]}, 16'(vecs[i].exp_c2));
      chk($sformatf("vec%0d_c3", i), {12'h0, cnt_w[3]}, 16'(vecs[i].exp_c3));
      chk($sformatf("vec%0d_flags", i), {12'h0, ov_w[3:2], un_w[3:2]}, 16'h0);
    end
    idle();

    sw_valid = 1; sw_write = 1; sw_mask = 16'hFFFF; sw_data = 16'h9753;
    tick("snap_load");
    idle();
    snap = 1; up = 4'hF;
    tick("snap_cap");
    idle();
    chk("snap_live", cnt_w, 16'hA864);
    sw_valid = 1; sw_mask = 16'hFFFF;
    #1;
    chk("snap_read", rd_w, 16'h9753);
    chk("snap_read_sat", rd_s, 16'h9753);
    sw_mask = 16'h0FF0;
    #1;
    chk("snap_read_mask", rd_w, 16'h0750);
    idle();

    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        clear[c] = ($urandom_range(0, 15) == 0);
        fc[c] = ($urandom_range(0, 7) == 0);
      end
      up = 4'($urandom); down = 4'($urandom);
      sw_valid = ($urandom_range(0, 3) == 0); sw_write = 1'($urandom);
      sw_mask = 16'($urandom); sw_data = 16'($urandom);
      snap = ($urandom_range(0, 3) == 0);
      tick("rand");
    end
    idle();

    up = 4'hF;
    tick("pre_async");
    #2;
    rst = 1;
    model_reset();
    #1;
    model_check("async_rst");
    #1;
    rst = 0;
    tick("post_async");
    chk("post_async_count", cnt_w, 16'h1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
